// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Stands in for the defines.v macros CPU_WIDTH, RESET_PC_VALUE and NOP_INST.
package if_stage_pkg;

    localparam int          CPU_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_VALUE = 32'h0000_1000;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_ctl_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with hold / bubble / load control.
import if_stage_pkg::*;

module if_id_reg #(
    parameter int          W   = 32,
    parameter logic [W-1:0] NOP = W'(32'h0000_0013)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  ifid_ctl_e    ctl,
    input  logic [W-1:0] ld_pc,
    input  logic [W-1:0] ld_inst,
    input  logic         ld_valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] inst,
    output logic         valid
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc    <= '0;
            inst  <= NOP;
            valid <= 1'b0;
        end else begin
            case (ctl)
                IFID_BUBBLE: begin
                    pc    <= '0;
                    inst  <= NOP;
                    valid <= 1'b0;
                end
                IFID_LOAD: begin
                    pc    <= ld_pc;
                    inst  <= ld_inst;
                    valid <= ld_valid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, sequences BOOT/RUN/HALT and feeds IF/ID.
import if_stage_pkg::*;

module if_stage #(
    parameter int                   CPU_WIDTH = if_stage_pkg::CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(RESET_PC_VALUE),
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = CPU_WIDTH'(if_stage_pkg::NOP_INST)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 redirect_i,
    input  logic [CPU_WIDTH-1:0] redirect_pc_i,
    input  logic                 halt_i,
    input  logic [CPU_WIDTH-1:0] inst_i,
    output logic [CPU_WIDTH-1:0] pc_addr_o,
    output logic [CPU_WIDTH-1:0] if_id_pc_o,
    output logic [CPU_WIDTH-1:0] if_id_inst_o,
    output logic                 if_id_valid_o,
    output logic                 misalign_o,
    output logic                 halted_o
);

    if_state_e              state_q, state_d;
    logic [CPU_WIDTH-1:0]   pc_q, pc_d;
    logic                   misalign_d;
    ifid_ctl_e              ifid_ctl;
    logic [CPU_WIDTH-1:0]   redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[CPU_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_o <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ifid_ctl   = IFID_HOLD;
        case (state_q)
            BOOT: begin
                ifid_ctl = IFID_BUBBLE;
                state_d  = RUN;
            end
            RUN: begin
                // redirect beats stall and halt; stall in turn masks halt
                if (redirect_i) begin
                    pc_d       = redirect_tgt;
                    ifid_ctl   = IFID_BUBBLE;
                    misalign_d = |redirect_pc_i[1:0];
                    state_d    = halt_i ? HALT : RUN;
                end else if (stall_i) begin
                    ifid_ctl = IFID_HOLD;
                end else if (halt_i) begin
                    ifid_ctl = IFID_BUBBLE;
                    state_d  = HALT;
                end else begin
                    ifid_ctl = IFID_LOAD;
                    pc_d     = pc_q + CPU_WIDTH'(4);
                end
            end
            HALT: begin
                ifid_ctl = IFID_BUBBLE;
                if (redirect_i) begin
                    pc_d       = redirect_tgt;
                    misalign_d = |redirect_pc_i[1:0];
                end else if (!halt_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                ifid_ctl = IFID_BUBBLE;
                state_d  = BOOT;
            end
        endcase
    end

    // flush only shapes the loaded slot; pc still advances through the load path
    if_id_reg #(.W(CPU_WIDTH), .NOP(NOP_INST)) u_if_id (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ctl      (ifid_ctl),
        .ld_pc    (pc_q),
        .ld_inst  (flush_i ? NOP_INST : inst_i),
        .ld_valid (!flush_i),
        .pc       (if_id_pc_o),
        .inst     (if_id_inst_o),
        .valid    (if_id_valid_o)
    );

    assign pc_addr_o = pc_q;
    assign halted_o  = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall, redirect, halt, wrap, flush, mid-run reset.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, redirect_i, halt_i;
    logic [31:0] redirect_pc_i, inst_i;
    logic [31:0] pc_addr_o, if_id_pc_o, if_id_inst_o;
    logic        if_id_valid_o, misalign_o, halted_o;

    int total = 0;
    int bad   = 0;

    if_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .inst_i(inst_i), .pc_addr_o(pc_addr_o), .if_id_pc_o(if_id_pc_o),
        .if_id_inst_o(if_id_inst_o), .if_id_valid_o(if_id_valid_o),
        .misalign_o(misalign_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory word i (byte address RESET_PC + 4*i) holds 32'h1000_0000 + i.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + ((a - 32'h0000_1000) >> 2);
    endfunction

    always_comb inst_i = mem(pc_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic v);
        check({tag, ".pc"},    if_id_pc_o,    pc);
        check({tag, ".inst"},  if_id_inst_o,  inst);
        check({tag, ".valid"}, {31'b0, if_id_valid_o}, {31'b0, v});
    endtask

    initial begin
        rst_i = 1; stall_i = 0; flush_i = 0; redirect_i = 0; halt_i = 0;
        redirect_pc_i = 32'h0;

        // reset
        tick();
        check("rst.pc_addr", pc_addr_o, 32'h0000_1000);
        chk_ifid("rst", 32'h0, 32'h13, 1'b0);
        check("rst.misalign", {31'b0, misalign_o}, 32'h0);
        check("rst.halted", {31'b0, halted_o}, 32'h0);
        tick();
        rst_i = 0;

        // BOOT cycle, then sequential fetch
        tick();
        check("boot.valid", {31'b0, if_id_valid_o}, 32'h0);
        check("boot.pc_addr", pc_addr_o, 32'h0000_1000);
        tick(); chk_ifid("seq0", 32'h0000_1000, 32'h1000_0000, 1'b1);
        tick(); chk_ifid("seq1", 32'h0000_1004, 32'h1000_0001, 1'b1);
        tick(); chk_ifid("seq2", 32'h0000_1008, 32'h1000_0002, 1'b1);
        check("seq.pc_addr", pc_addr_o, 32'h0000_100C);

        // stall for 3 cycles, flush ignored while stalled
        stall_i = 1; flush_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall", 32'h0000_1008, 32'h1000_0002, 1'b1);
            check("stall.pc_addr", pc_addr_o, 32'h0000_100C);
        end
        stall_i = 0; flush_i = 0;
        tick(); chk_ifid("unstall", 32'h0000_100C, 32'h1000_0003, 1'b1);
        check("unstall.pc_addr", pc_addr_o, 32'h0000_1010);

        // redirect overriding stall
        redirect_i = 1; redirect_pc_i = 32'h0000_0100; stall_i = 1;
        tick();
        check("redir.pc_addr", pc_addr_o, 32'h0000_0100);
        check("redir.valid", {31'b0, if_id_valid_o}, 32'h0);
        check("redir.misalign", {31'b0, misalign_o}, 32'h0);
        redirect_i = 0; stall_i = 0;
        tick(); chk_ifid("redir.next", 32'h0000_0100, mem(32'h0000_0100), 1'b1);

        // misaligned redirect
        redirect_i = 1; redirect_pc_i = 32'h0000_0102;
        tick();
        check("mis.pc_addr", pc_addr_o, 32'h0000_0100);
        check("mis.pulse", {31'b0, misalign_o}, 32'h1);
        redirect_i = 0;
        tick();
        check("mis.clear", {31'b0, misalign_o}, 32'h0);
        chk_ifid("mis.next", 32'h0000_0100, mem(32'h0000_0100), 1'b1);

        // halt for 4 cycles then resume
        halt_i = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt.halted", {31'b0, halted_o}, 32'h1);
            check("halt.valid", {31'b0, if_id_valid_o}, 32'h0);
            check("halt.pc_addr", pc_addr_o, 32'h0000_0104);
        end
        halt_i = 0;
        tick();
        check("resume.halted", {31'b0, halted_o}, 32'h0);
        check("resume.valid", {31'b0, if_id_valid_o}, 32'h0);
        tick(); chk_ifid("resume.first", 32'h0000_0104, mem(32'h0000_0104), 1'b1);

        // PC wrap
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        check("wrap.pc_addr0", pc_addr_o, 32'hFFFF_FFFC);
        redirect_i = 0;
        tick();
        check("wrap.pc_addr1", pc_addr_o, 32'h0000_0000);
        chk_ifid("wrap.ifid", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1);
        tick(); chk_ifid("wrap.ifid2", 32'h0000_0000, mem(32'h0000_0000), 1'b1);

        // flush on an unstalled fetch: slot squashed, pc advances
        flush_i = 1;
        tick();
        check("flush.inst", if_id_inst_o, 32'h13);
        check("flush.valid", {31'b0, if_id_valid_o}, 32'h0);
        check("flush.pc_addr", pc_addr_o, 32'h0000_0008);
        flush_i = 0;
        tick(); chk_ifid("flush.next", 32'h0000_0008, mem(32'h0000_0008), 1'b1);

        // reset while halted with a redirect pending
        halt_i = 1;
        tick();
        check("pre_rst.halted", {31'b0, halted_o}, 32'h1);
        rst_i = 1; redirect_i = 1; redirect_pc_i = 32'h0000_0203;
        tick();
        check("mrst.pc_addr", pc_addr_o, 32'h0000_1000);
        check("mrst.halted", {31'b0, halted_o}, 32'h0);
        check("mrst.misalign", {31'b0, misalign_o}, 32'h0);
        chk_ifid("mrst", 32'h0, 32'h13, 1'b0);
        rst_i = 0; redirect_i = 0; halt_i = 0;
        tick();
        check("mrst.boot.valid", {31'b0, if_id_valid_o}, 32'h0);
        tick(); chk_ifid("mrst.run", 32'h0000_1000, 32'h1000_0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue RISC-V pipeline.
- Owns the program counter and drives it combinationally to the instruction memory, which returns the instruction in the same cycle.
- Captures the (PC, instruction) pair into the IF/ID pipeline register consumed by decode.
- Handles hazard stalls, flushes, branch/jump redirects and a debug halt.

Parameters:
- CPU_WIDTH, 32, datapath/address width (from defines.v).
- RESET_PC, `RESET_PC_VALUE, PC loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- flush_i  in  1  insert a bubble into IF/ID.
- redirect_i  in  1  branch/jump taken.
- redirect_pc_i  in  CPU_WIDTH  redirect target.
- halt_i  in  1  debug halt request, level.
- inst_i  in  CPU_WIDTH  instruction from instruction memory (combinational).
- pc_addr_o  out  CPU_WIDTH  current PC to instruction memory.
- if_id_pc_o  out  CPU_WIDTH  registered PC to decode.
- if_id_inst_o  out  CPU_WIDTH  registered instruction to decode.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  one-cycle pulse: redirect target had [1:0] != 0.
- halted_o  out  1  FSM is in HALT.

Behaviour:
- All state updates on the rising edge of clk_i. Reset is synchronous, active-high, and has top priority.
- Reset values:
  - pc = RESET_PC
  - if_id_pc_o = 0
  - if_id_inst_o = NOP_INST
  - if_id_valid_o = 0
  - misalign_o = 0
  - halted_o = 0
  - state = BOOT
- pc_addr_o = pc at all times. Fetch latency: instruction is visible on if_id_* one cycle after its PC is driven.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset release. IF/ID loads a bubble; PC holds. Next state is RUN unconditionally.
  - RUN, priority high to low:
    1. redirect_i: pc <= {redirect_pc_i[31:2], 2'b00}; IF/ID <= bubble; misalign_o <= |redirect_pc_i[1:0]. Overrides stall_i and halt_i for this cycle; next state is HALT if halt_i, else RUN.
    2. stall_i: pc and IF/ID hold (even if flush_i); state holds. halt_i is ignored while stalled.
    3. halt_i: pc holds; IF/ID <= bubble; next state HALT.
    4. Otherwise: if_id_pc <= pc; if_id_inst <= flush_i ? NOP_INST : inst_i; if_id_valid <= !flush_i; pc <= pc + 4.
  - PC increment wraps modulo 2^CPU_WIDTH (32'hFFFF_FFFC + 4 = 0).
  - HALT: halted_o = 1; IF/ID <= bubble every cycle.
    - redirect_i: updates pc; misalign_o pulses; stays in HALT.
    - halt_i = 0: next state RUN, with pc unchanged. The first post-halt instruction appears in IF/ID two edges after halt_i deasserts.
- Bubble means valid = 0, inst = NOP_INST, pc = 0.
- misalign_o defaults to 0 in every cycle without a misaligned redirect.
- flush_i with redirect_i: identical to redirect_i alone.
- Reset mid-operation (any state): all registers return to reset values at that edge; pending redirect and halt are discarded.

Decomposition:
- Shared defines.v supplies CPU_WIDTH, RESET_PC_VALUE, and a new NOP_INST macro.
- FSM state encodings are local parameters: BOOT=2'd0, RUN=2'd1, HALT=2'd2. Unused code 2'd3 recovers to BOOT.
- One natural sub-module: if_id_reg, the pipeline register with hold/bubble/load controls. The PC/FSM logic stays in if_stage.

Test Plan:
1. Reset, sequential fetch: rst_i high 2 cycles, then low; memory word i = 32'h1000_0000+i.
   - Cycle 1: valid = 0 (BOOT).
   - Then if_id_pc = RESET_PC, RESET_PC+4, …, with matching instructions and valid = 1.
2. Stall: assert stall_i for 3 cycles mid-stream.
   - if_id_* and pc_addr_o frozen for 3 cycles.
   - Sequence resumes with no skipped or duplicated PC.
3. Redirect:
   - redirect_i with redirect_pc_i = 32'h0000_0100, simultaneous with stall_i: next pc_addr_o = 0x100, valid = 0; following cycle if_id_pc = 0x100.
   - Repeat with target 0x102: pc_addr_o = 0x100, misalign_o high for exactly 1 cycle.
4. Halt/resume:
   - halt_i high 4 cycles: halted_o = 1 from the next edge; valid = 0; pc frozen.
   - Drop halt_i: halted_o low after 1 edge; the held PC appears in IF/ID after 2 edges.
5. Wrap and flush:
   - Redirect to 32'hFFFF_FFFC, run 2 cycles: pc_addr_o = 0 after the first fetch.
   - flush_i during a non-stalled fetch: that slot becomes NOP_INST with valid = 0, and pc still advances.
6. Reset mid-operation: assert rst_i while in HALT with a redirect pending.
   - Next edge: pc = RESET_PC, halted_o = 0, valid = 0, state BOOT.
